// File: rtl/imem_loader.sv
// Program loader: takes a length-prefixed little-endian byte stream and writes
// 32-bit words to instruction memory, holding the core in reset until it is done.
module imem_loader #(
  parameter int MAX_WORDS = 64,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             imem_we,
  output logic [63:0]      imem_addr,
  output logic [31:0]      imem_wdata,
  output logic             core_hold,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] word_count,
  output logic [2:0]       dbg_state
);

  // Handshake: a byte moves on a rising edge where byte_valid && byte_ready;
  // byte_ready depends on state only, so the producer never sees a combinational loop.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_e;

  localparam logic [8:0] MAX_LEN = 9'(MAX_WORDS);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [1:0]       i_q, i_d;
  logic [CNT_W-1:0] k_q, k_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [CNT_W-1:0] wc_q, wc_d;
  logic             xfer;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      i_q     <= '0;
      k_q     <= '0;
      wdata_q <= '0;
      wc_q    <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      i_q     <= i_d;
      k_q     <= k_d;
      wdata_q <= wdata_d;
      wc_q    <= wc_d;
    end
  end

  assign xfer = byte_valid && byte_ready;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    i_d     = i_q;
    k_d     = k_q;
    wdata_d = wdata_q;
    wc_d    = wc_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LEN;
          wc_d    = '0;
        end
      end
      S_LEN: begin
        if (xfer) begin
          if (byte_data == 8'd0 || {1'b0, byte_data} > MAX_LEN) begin
            state_d = S_ERR;
          end else begin
            n_d     = CNT_W'(byte_data);
            i_d     = '0;
            k_d     = '0;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          wdata_d[{i_q, 3'b000} +: 8] = byte_data;
          i_d = i_q + 2'd1;
          if (i_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        wc_d = wc_q + CNT_W'(1);
        i_d  = '0;
        // k stays on the last word so imem_addr never exceeds 4*(MAX_WORDS-1).
        if ((k_q + CNT_W'(1)) == n_q) begin
          state_d = S_DONE;
        end else begin
          k_d     = k_q + CNT_W'(1);
          state_d = S_DATA;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign byte_ready = (state_q == S_LEN) || (state_q == S_DATA);
  assign imem_we    = (state_q == S_WRITE);
  assign busy       = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_WRITE);
  assign done       = (state_q == S_DONE);
  assign error      = (state_q == S_ERR);
  assign core_hold  = (state_q != S_DONE);
  assign imem_addr  = {{(62-CNT_W){1'b0}}, k_q, 2'b00};
  assign imem_wdata = wdata_q;
  assign word_count = wc_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: random and directed load sessions checked against a
// stream-level model of the expected memory writes.
module tb_imem_loader;

  localparam int MAX_WORDS = 64;
  localparam int CNT_W     = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             byte_valid = 1'b0;
  logic [7:0]       byte_data = 8'h00;
  logic             byte_ready;
  logic             imem_we;
  logic [63:0]      imem_addr;
  logic [31:0]      imem_wdata;
  logic             core_hold;
  logic             busy;
  logic             done;
  logic             error;
  logic [CNT_W-1:0] word_count;
  logic [2:0]       dbg_state;

  imem_loader #(.MAX_WORDS(MAX_WORDS), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_hold  (core_hold),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .word_count (word_count),
    .dbg_state  (dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  int n_checks = 0;
  int n_pass   = 0;
  int we_cnt   = 0;

  logic [95:0] exp_q[$];   // {addr, data} of each expected write
  logic [7:0]  stim_q[$];
  logic [31:0] words_q[$];
  logic [95:0] mon_e;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // scoreboard: every write pulse must match the next expected write
  always @(negedge clk) begin
    if (reset && imem_we) begin
      we_cnt++;
      check("ready_in_write", 64'(byte_ready), 64'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_we", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", imem_addr, mon_e[95:32]);
        check("wr_data", 64'(imem_wdata), 64'(mon_e[31:0]));
      end
    end
  end

  // model: stream = N then each word LSB first; word k lands at byte address 4k
  task automatic plan_load(input int n);
    logic [31:0] w;
    stim_q = {};
    stim_q.push_back(8'(n));
    for (int k = 0; k < words_q.size(); k++) begin
      w = words_q[k];
      for (int j = 0; j < 4; j++) stim_q.push_back(w[8*j +: 8]);
      exp_q.push_back({64'(4 * k), w});
    end
  endtask

  task automatic random_words(input int n);
    words_q = {};
    for (int k = 0; k < n; k++) words_q.push_back($urandom);
  endtask

  // driver tasks
  task automatic pulse_start(output int s);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    s = cyc_cnt;
    check("ready_after_start", 64'(byte_ready), 64'd1);
    check("hold_after_start", 64'(core_hold), 64'd1);
    check("done_after_start", 64'(done), 64'd0);
    check("err_after_start", 64'(error), 64'd0);
    check("wc_after_start", 64'(word_count), 64'd0);
  endtask

  task automatic drive_stream(input int gap_pct, input int mid_start_at);
    int  idx = 0;
    int  cyc = 0;
    int  budget;
    bit  xfer;
    bit  mid_done = 1'b0;
    budget = stim_q.size() * 30 + 50;
    while (idx < stim_q.size() && cyc < budget) begin
      @(negedge clk);
      byte_valid = ($urandom_range(99) >= gap_pct);
      byte_data  = byte_valid ? stim_q[idx] : 8'($urandom);
      start = 1'b0;
      if (mid_start_at >= 0 && idx == mid_start_at && !mid_done) begin
        start    = 1'b1;
        mid_done = 1'b1;
      end
      #1;
      xfer = byte_valid && byte_ready;
      @(posedge clk);
      #1;
      if (xfer) idx++;
      cyc++;
    end
    byte_valid = 1'b0;
    start      = 1'b0;
    if (idx < stim_q.size()) check("stream_timeout", 64'(idx), 64'(stim_q.size()));
  endtask

  task automatic wait_end();
    int c = 0;
    while (!(done || error) && c < 40) begin
      @(negedge clk);
      c++;
    end
    if (!(done || error)) check("end_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_load(input int gap_pct, input int mid_start_at, input bit chk_time);
    int n;
    int s;
    int we0;
    n   = words_q.size();
    we0 = we_cnt;
    plan_load(n);
    pulse_start(s);
    drive_stream(gap_pct, mid_start_at);
    wait_end();
    check("done", 64'(done), 64'd1);
    check("error_clear", 64'(error), 64'd0);
    check("core_released", 64'(core_hold), 64'd0);
    check("busy_low", 64'(busy), 64'd0);
    check("word_count", 64'(word_count), 64'(n));
    check("we_pulses", 64'(we_cnt - we0), 64'(n));
    check("exp_drained", 64'(exp_q.size()), 64'd0);
    if (chk_time) check("session_cycles", 64'(cyc_cnt - s + 1), 64'(2 + 5 * n));
  endtask

  task automatic run_illegal(input int len);
    int s;
    int we0;
    we0 = we_cnt;
    words_q = {};
    plan_load(len);
    pulse_start(s);
    drive_stream(0, -1);
    check("err_rise", 64'(error), 64'd1);
    check("err_hold", 64'(core_hold), 64'd1);
    check("err_busy", 64'(busy), 64'd0);
    check("err_ready", 64'(byte_ready), 64'd0);
    repeat (5) @(negedge clk);
    check("err_no_we", 64'(we_cnt - we0), 64'd0);
    check("err_wc", 64'(word_count), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    // reset state
    repeat (2) @(negedge clk);
    check("rst_hold", 64'(core_hold), 64'd1);
    check("rst_ready", 64'(byte_ready), 64'd0);
    check("rst_we", 64'(imem_we), 64'd0);
    check("rst_addr", imem_addr, 64'd0);
    check("rst_wdata", 64'(imem_wdata), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_wc", 64'(word_count), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // nominal program at full rate, with session length checked
    words_q = {32'h0000_0013, 32'h0010_0093};
    run_load(0, -1, 1'b1);

    // same program with random valid gaps
    words_q = {32'h0000_0013, 32'h0010_0093};
    run_load(40, -1, 1'b0);

    // illegal lengths, then a good load clears error
    run_illegal(0);
    run_illegal(MAX_WORDS + 1);
    random_words(3);
    run_load(20, -1, 1'b0);

    // start during DATA is ignored; start from DONE restarts
    random_words(3);
    run_load(0, 6, 1'b0);
    words_q = {32'hDEAD_BEEF};
    run_load(0, -1, 1'b1);

    // reset after two data bytes aborts the session
    random_words(3);
    plan_load(3);
    exp_q = {};
    stim_q = stim_q[0:2];
    pulse_start(s);
    drive_stream(0, -1);
    @(negedge clk);
    s = we_cnt;
    reset = 1'b0;
    #1;
    check("abort_hold", 64'(core_hold), 64'd1);
    check("abort_ready", 64'(byte_ready), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_wc", 64'(word_count), 64'd0);
    check("abort_we", 64'(imem_we), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    check("abort_no_we", 64'(we_cnt - s), 64'd0);
    random_words(2);
    run_load(0, -1, 1'b1);

    // random sessions
    for (int r = 0; r < 6; r++) begin
      random_words($urandom_range(1, 10));
      run_load($urandom_range(0, 50), -1, 1'b0);
    end

    // maximum length with an incrementing byte pattern
    words_q = {};
    for (int k = 0; k < MAX_WORDS; k++)
      words_q.push_back({8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)});
    run_load(10, -1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
